// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory that answers one cache request at a time.
// Define DMEM_ADDR_CHECK_EN to flag addresses beyond the array through err_o.
module dmem_line_responder #(
   parameter int unsigned LATENCY     = 10,
   parameter int unsigned DEPTH_LINES = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o,
   output logic         busy_o,
   output logic         err_o
);
   localparam int unsigned IDX_W    = $clog2(DEPTH_LINES);
   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_WAIT   = 2'd1;
   localparam logic [1:0]  S_ACK    = 2'd2;
   localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

   logic [1:0]       r_state;
   logic [7:0]       r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             r_write;
   logic [255:0]     r_wdata;
   logic             r_oor;
   logic             r_ack;
   logic             r_err;
   logic [255:0]     r_rdata;
   logic [255:0]     r_mem [DEPTH_LINES];

   logic w_oor;
   logic w_commit;
   logic w_mem_we;
   logic w_unused;

`ifdef DMEM_ADDR_CHECK_EN
   assign w_oor = |addr_i[31:5+IDX_W];
`else
   assign w_oor = 1'b0;
`endif
   // Byte offset bits never matter; upper bits only matter with the range check.
   assign w_unused = &{1'b0, addr_i[4:0], addr_i[31:5+IDX_W]};

   assign w_commit = (r_state == S_WAIT) && (r_cnt == 8'd0);
   assign w_mem_we = w_commit && r_write && !r_oor && !rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_idx   <= {IDX_W{1'b0}};
         r_write <= 1'b0;
         r_wdata <= {256{1'b0}};
         r_oor   <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= {256{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               if (enable_i) begin
                  r_idx   <= addr_i[IDX_W+4:5];
                  r_write <= write_i;
                  r_wdata <= data_i;
                  r_oor   <= w_oor;
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (r_cnt == 8'd0) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
                  r_err   <= r_oor;
                  if (!r_write) begin
                     r_rdata <= r_oor ? {256{1'b0}} : r_mem[r_idx];
                  end else begin
                     r_rdata <= r_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   // Array is never reset so contents survive a reset pulse.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign ack_o  = r_ack;
   assign err_o  = r_err;
   assign data_o = r_rdata;
   assign busy_o = (r_state != S_IDLE);
endmodule
